// File: rtl/team_09_pkg.sv
// Shared constants, state type and helpers for the team_09 pushbutton front end.
package team_09_pkg;

  localparam int unsigned KEY_NUM_PB         = 21;
  localparam int unsigned KEY_CODE_W         = 5;
  localparam int unsigned KEY_TICK_DIV       = 10000;
  localparam int unsigned KEY_STABLE_SAMPLES = 4;

  typedef enum logic {KS_IDLE, KS_HOLD} key_state_t;

  // Index of the lowest set bit; 0 when vec is empty (callers gate on vec != 0).
  function automatic int unsigned lowest_set(input logic [31:0] vec);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 32; i > 0; i--) begin
      if (vec[i-1]) idx = i - 1;
    end
    return idx;
  endfunction

endpackage

// File: rtl/team_09_pb_debounce_cell.sv
// One pushbutton: 2-FF synchronizer, tick-sampled debounce counter, level and edge pulses.
module team_09_pb_debounce_cell
  import team_09_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = KEY_STABLE_SAMPLES
) (
  input  logic clk,
  input  logic nrst,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  localparam int unsigned CW = $clog2(STABLE_SAMPLES);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;

  // Synchronizer chain runs regardless of enable.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce decision, evaluated only on sample ticks.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (tick_i) begin
      if (sync2_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CW'(STABLE_SAMPLES - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
        press_d = ~level_q;
        rel_d   = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Debounce state and registered edge pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

// File: rtl/team_09_pb_keyscan.sv
// Pushbutton scanner: shared prescaler, per-button debounce, pending bitmap and
// lowest-index-first valid/ready key-code delivery.
module team_09_pb_keyscan
  import team_09_pkg::*;
#(
  parameter int unsigned NUM_PB         = KEY_NUM_PB,
  parameter int unsigned CODE_W         = KEY_CODE_W,
  parameter int unsigned TICK_DIV       = KEY_TICK_DIV,
  parameter int unsigned STABLE_SAMPLES = KEY_STABLE_SAMPLES
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic [NUM_PB-1:0] pb_raw,
  output logic [NUM_PB-1:0] pb_level,
  output logic [NUM_PB-1:0] pb_press,
  output logic [NUM_PB-1:0] pb_release,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  input  logic              key_ready,
  output logic              key_merge
);

  localparam int unsigned PW = $clog2(TICK_DIV);

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [NUM_PB-1:0] pending_q, pending_d;
  logic [NUM_PB-1:0] load_mask;
  logic [CODE_W-1:0] code_q, code_d;
  logic              merge_q, merge_d;
  key_state_t        state_q, state_d;
  int unsigned       low_idx;

  assign tick = en && (presc_q == PW'(TICK_DIV - 1));

  // Prescaler next count: frozen while disabled, wraps after the tick cycle.
  always_comb begin
    presc_d = presc_q;
    if (en) presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) presc_q <= '0;
    else       presc_q <= presc_d;
  end

  for (genvar g = 0; g < NUM_PB; g++) begin : g_cell
    team_09_pb_debounce_cell #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_cell (
      .clk      (clk),
      .nrst     (nrst),
      .tick_i   (tick),
      .raw_i    (pb_raw[g]),
      .level_o  (pb_level[g]),
      .press_o  (pb_press[g]),
      .release_o(pb_release[g])
    );
  end

  // Output FSM plus pending bitmap update; a press landing on the bit being loaded re-queues it.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    load_mask = '0;
    low_idx   = lowest_set(32'(pending_q));
    case (state_q)
      KS_IDLE: begin
        if (pending_q != '0) begin
          for (int unsigned i = 0; i < NUM_PB; i++) begin
            if (i == low_idx) load_mask[i] = 1'b1;
          end
          code_d  = CODE_W'(low_idx);
          state_d = KS_HOLD;
        end
      end
      KS_HOLD: begin
        if (key_ready) state_d = KS_IDLE;
      end
      default: state_d = KS_IDLE;
    endcase
    merge_d   = |(pb_press & pending_q & ~load_mask);
    pending_d = (pending_q & ~load_mask) | pb_press;
  end

  // Handshake and queue state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= KS_IDLE;
      pending_q <= '0;
      code_q    <= '0;
      merge_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      merge_q   <= merge_d;
    end
  end

  assign key_valid = (state_q == KS_HOLD);
  assign key_code  = code_q;
  assign key_merge = merge_q;

endmodule

// File: tb/tb_team_09_pb_keyscan.sv
// Self-checking bench for team_09_pb_keyscan with a behavioural reference model.
module tb_team_09_pb_keyscan;

  localparam int NPB = 21;
  localparam int CW  = 5;
  localparam int TD  = 4;
  localparam int SS  = 3;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           en = 1'b1;
  logic [NPB-1:0] pb_raw = '1;
  logic [NPB-1:0] pb_level, pb_press, pb_release;
  logic           key_valid, key_ready = 1'b0, key_merge;
  logic [CW-1:0]  key_code;

  team_09_pb_keyscan #(
    .NUM_PB(NPB), .CODE_W(CW), .TICK_DIV(TD), .STABLE_SAMPLES(SS)
  ) dut (
    .clk(clk), .nrst(nrst), .en(en), .pb_raw(pb_raw),
    .pb_level(pb_level), .pb_press(pb_press), .pb_release(pb_release),
    .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
    .key_merge(key_merge)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  bit [NPB-1:0] h1, h2;          // raw input two samples back
  int           presc;
  int           run_len [NPB];   // consecutive ticks the synced input differed from level
  bit [NPB-1:0] m_lvl, m_press, m_rel, m_pend;
  bit           m_valid, m_merge;
  int           m_code;

  task automatic model_reset();
    h1 = '0; h2 = '0; presc = 0;
    for (int i = 0; i < NPB; i++) run_len[i] = 0;
    m_lvl = '0; m_press = '0; m_rel = '0; m_pend = '0;
    m_valid = 0; m_merge = 0; m_code = 0;
  endtask

  task automatic model_step();
    bit           tk;
    bit [NPB-1:0] nl, np, nr, load;
    int           low;
    tk = en && (presc == TD - 1);
    if (en) presc = (presc + 1) % TD;
    nl = m_lvl; np = '0; nr = '0;
    if (tk) begin
      for (int i = 0; i < NPB; i++) begin
        if (h2[i] != m_lvl[i]) begin
          run_len[i] = run_len[i] + 1;
          if (run_len[i] == SS) begin
            nl[i] = ~m_lvl[i];
            np[i] = nl[i];
            nr[i] = m_lvl[i];
            run_len[i] = 0;
          end
        end else begin
          run_len[i] = 0;
        end
      end
    end
    load = '0;
    if (!m_valid) begin
      if (m_pend != '0) begin
        low = 0;
        for (int i = NPB - 1; i >= 0; i--) if (m_pend[i]) low = i;
        load[low] = 1'b1;
        m_code = low;
        m_valid = 1;
      end
    end else if (key_ready) begin
      m_valid = 0;
    end
    m_merge = |(m_press & m_pend & ~load);
    m_pend  = (m_pend & ~load) | m_press;
    m_press = np; m_rel = nr; m_lvl = nl;
    h2 = h1; h1 = pb_raw;
  endtask

  always @(posedge clk or negedge nrst) begin
    if (!nrst) model_reset();
    else       model_step();
  end

  // ---------------- per-cycle compare and event recording ----------------
  int cyc = 0;
  int merges = 0;
  int acc_code [$];
  int acc_cyc  [$];

  task automatic on_negedge();
    cyc++;
    chk("pb_level",   32'(pb_level),   32'(m_lvl));
    chk("pb_press",   32'(pb_press),   32'(m_press));
    chk("pb_release", 32'(pb_release), 32'(m_rel));
    chk("key_valid",  32'(key_valid),  32'(m_valid));
    chk("key_code",   32'(key_code),   m_code);
    chk("key_merge",  32'(key_merge),  32'(m_merge));
    if (nrst && key_valid && key_ready) begin
      acc_code.push_back(int'(key_code));
      acc_cyc.push_back(cyc);
    end
    if (nrst && key_merge) merges++;
  endtask

  always @(negedge clk) on_negedge();

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int  lvl_at, kv_at, presses, n;
    bit  seen, found;

    // 1. reset with all buttons pressed, then a single held button 5
    wait_cyc(3);
    chk("t1_rst_level",   32'(pb_level),   0);
    chk("t1_rst_press",   32'(pb_press),   0);
    chk("t1_rst_release", 32'(pb_release), 0);
    chk("t1_rst_valid",   32'(key_valid),  0);
    chk("t1_rst_code",    32'(key_code),   0);
    chk("t1_rst_merge",   32'(key_merge),  0);
    pb_raw = '0; pb_raw[5] = 1'b1;
    nrst = 1'b1;
    lvl_at = 0; kv_at = 0; presses = 0;
    for (int k = 1; k <= 12 * TD; k++) begin
      @(negedge clk);
      if (pb_press[5]) presses++;
      if (pb_level[5] && lvl_at == 0) lvl_at = k;
      if (key_valid && kv_at == 0) kv_at = k;
    end
    chk("t1_level_cycle", lvl_at, 12);
    chk("t1_valid_cycle", kv_at, 14);
    chk("t1_press_count", presses, 1);
    chk("t1_code", 32'(key_code), 5);
    pb_raw = '0;
    key_ready = 1'b1;
    wait_cyc(30);
    chk("t1_accept_count", acc_code.size(), 1);
    if (acc_code.size() > 0) chk("t1_accept_code", acc_code[0], 5);

    // 2. two-tick glitch on button 0 must be swallowed
    acc_code.delete(); acc_cyc.delete();
    seen = 0;
    pb_raw[0] = 1'b1;
    for (int k = 0; k < 2 * TD; k++) begin
      @(negedge clk);
      if (pb_level[0] || pb_press[0] || key_valid) seen = 1;
    end
    pb_raw[0] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (pb_level[0] || pb_press[0] || key_valid) seen = 1;
    end
    chk("t2_glitch_seen", 32'(seen), 0);

    // 3. simultaneous presses served lowest index first
    acc_code.delete(); acc_cyc.delete();
    pb_raw[7] = 1'b1; pb_raw[2] = 1'b1; pb_raw[12] = 1'b1;
    wait_cyc(40);
    chk("t3_accept_count", acc_code.size(), 3);
    if (acc_code.size() == 3) begin
      chk("t3_code0", acc_code[0], 2);
      chk("t3_code1", acc_code[1], 7);
      chk("t3_code2", acc_code[2], 12);
      chk("t3_gap01", acc_cyc[1] - acc_cyc[0], 2);
      chk("t3_gap12", acc_cyc[2] - acc_cyc[1], 2);
    end
    chk("t3_valid_after", 32'(key_valid), 0);
    pb_raw = '0;
    wait_cyc(30);

    // 4. backpressure: slot holds 3, re-press queues 3, third press merges
    key_ready = 1'b0;
    acc_code.delete(); acc_cyc.delete();
    merges = 0;
    for (int p = 0; p < 3; p++) begin
      pb_raw[3] = 1'b1; wait_cyc(20);
      pb_raw[3] = 1'b0; wait_cyc(20);
    end
    chk("t4_valid_held", 32'(key_valid), 1);
    chk("t4_code_held", 32'(key_code), 3);
    chk("t4_merge_count", merges, 1);
    key_ready = 1'b1;
    wait_cyc(10);
    chk("t4_accept_count", acc_code.size(), 2);
    if (acc_code.size() == 2) begin
      chk("t4_accept0", acc_code[0], 3);
      chk("t4_accept1", acc_code[1], 3);
    end
    chk("t4_valid_after", 32'(key_valid), 0);

    // 5. enable dropped mid-debounce; handshake still completes meanwhile
    key_ready = 1'b0;
    pb_raw[4] = 1'b1; wait_cyc(20);
    pb_raw[4] = 1'b0; wait_cyc(20);
    chk("t5_slot_code", 32'(key_code), 4);
    acc_code.delete(); acc_cyc.delete();
    pb_raw[9] = 1'b1;
    wait_cyc(2 * TD);
    en = 1'b0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 10) key_ready = 1'b1;
      if (pb_level[9] || pb_release[4]) seen = 1;
    end
    chk("t5_frozen_level", 32'(seen), 0);
    chk("t5_valid_while_off", 32'(key_valid), 0);
    chk("t5_accept_while_off", acc_code.size(), 1);
    if (acc_code.size() > 0) chk("t5_accept_code", acc_code[0], 4);
    en = 1'b1;
    found = 0; n = 0;
    for (int k = 1; k <= 3 * TD + 4; k++) begin
      @(negedge clk);
      if (!found && pb_level[9]) begin found = 1; n = k; end
    end
    chk("t5_flip_in_budget", 32'(found && n >= 1 && n <= 3 * TD), 1);
    wait_cyc(10);
    pb_raw = '0;
    wait_cyc(30);

    // 6. reset while holding a slot with pending 0x0081
    key_ready = 1'b0;
    acc_code.delete(); acc_cyc.delete();
    pb_raw[4] = 1'b1; wait_cyc(20);
    pb_raw[4] = 1'b0;
    pb_raw[0] = 1'b1; pb_raw[7] = 1'b1; wait_cyc(20);
    chk("t6_pre_valid", 32'(key_valid), 1);
    chk("t6_pre_code", 32'(key_code), 4);
    pb_raw = '0;
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    chk("t6_async_valid", 32'(key_valid), 0);
    chk("t6_async_level", 32'(pb_level), 0);
    wait_cyc(3);
    key_ready = 1'b1;
    nrst = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (key_valid) seen = 1;
    end
    chk("t6_no_keys", 32'(seen), 0);
    chk("t6_accept_count", acc_code.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
